// File: rtl/cw_key_pkg.sv
// Shared types and elaboration helpers for the key conditioner.
package cw_key_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEB_PRESS,
    ST_HELD,
    ST_REPEAT,
    ST_DEB_REL
  } key_state_e;

  function automatic int ms_to_cycles(input int ms, input int clk_hz);
    return (ms * clk_hz) / 1000;
  endfunction

  // One counter width wide enough for every timer in a channel.
  function automatic int cnt_width(input int deb, input int long_c, input int rpt);
    int m;
    m = deb;
    if (long_c > m) m = long_c;
    if (rpt > m) m = rpt;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/cw_key_channel.sv
// One key: 2-flop synchronizer, debounce/hold/repeat FSM and registered event outputs.
//   state        | meaning
//   ST_IDLE      | key released and stable
//   ST_DEB_PRESS | pressed level seen, counting stable press time
//   ST_HELD      | accepted press, counting toward long-press
//   ST_REPEAT    | long-press reached, emitting auto-repeat steps
//   ST_DEB_REL   | released level seen, counting stable release time
module cw_key_channel
  import cw_key_pkg::*;
#(
  parameter int DEB  = 20,
  parameter int LONG = 800,
  parameter int RPT  = 200,
  parameter int CW   = 10
) (
  input  logic Clk,
  input  logic pRst,
  input  logic key_n,
  input  logic en,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic step
);

  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] DEB_C   = CW'(DEB);
  localparam logic [CW-1:0] LONG_C  = CW'(LONG);
  localparam logic [CW-1:0] LONG_M1 = CW'(LONG - 1);
  localparam logic [CW-1:0] RPT_M1  = CW'(RPT - 1);

  key_state_e    state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d, hold_q, hold_d, rep_q, rep_d;
  logic          origin_q, origin_d;
  logic          level_q, level_d, press_q, press_d, rel_q, rel_d;
  logic          long_q, long_d, step_q, step_d;
  logic          s, adv_held, adv_rep;

  assign s = ~sync_q[1];

  always_comb begin
    sync_d   = {sync_q[0], key_n};
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    rep_d    = rep_q;
    origin_d = origin_q;
    level_d  = level_q;
    press_d  = 1'b0;
    rel_d    = 1'b0;
    long_d   = 1'b0;
    step_d   = 1'b0;
    adv_held = 1'b0;
    adv_rep  = 1'b0;
    case (state_q)
      ST_IDLE: if (s) begin
        state_d = ST_DEB_PRESS;
        cnt_d   = ONE;
      end
      ST_DEB_PRESS: begin
        if (!s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_C) begin
          state_d = ST_HELD;
          level_d = 1'b1;
          press_d = en;
          step_d  = en;
          hold_d  = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_HELD: begin
        if (!s) begin
          state_d  = ST_DEB_REL;
          cnt_d    = ONE;
          origin_d = 1'b0;
        end else begin
          adv_held = 1'b1;
        end
      end
      ST_REPEAT: begin
        if (!s) begin
          state_d  = ST_DEB_REL;
          cnt_d    = ONE;
          origin_d = 1'b1;
        end else begin
          adv_rep = 1'b1;
        end
      end
      ST_DEB_REL: begin
        // A release bounce resumes the origin timer on this very edge, so only
        // the cycles actually spent in ST_DEB_REL are lost from the schedule.
        if (s) begin
          state_d  = origin_q ? ST_REPEAT : ST_HELD;
          cnt_d    = '0;
          adv_held = ~origin_q;
          adv_rep  = origin_q;
        end else if (cnt_q == DEB_C) begin
          state_d = ST_IDLE;
          level_d = 1'b0;
          rel_d   = en;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (adv_held) begin
      if (hold_q == LONG_M1) begin
        hold_d  = LONG_C;
        long_d  = en;
        state_d = ST_REPEAT;
        rep_d   = '0;
      end else if (hold_q != LONG_C) begin
        hold_d = hold_q + ONE;
      end
    end
    if (adv_rep) begin
      if (rep_q == RPT_M1) begin
        rep_d  = '0;
        step_d = en;
      end else begin
        rep_d = rep_q + ONE;
      end
    end
  end

  always_ff @(posedge Clk or posedge pRst) begin
    if (pRst) begin
      sync_q   <= 2'b11;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hold_q   <= '0;
      rep_q    <= '0;
      origin_q <= 1'b0;
      level_q  <= 1'b0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
      long_q   <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      rep_q    <= rep_d;
      origin_q <= origin_d;
      level_q  <= level_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      long_q   <= long_d;
      step_q   <= step_d;
    end
  end

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign long_pulse    = long_q;
  assign step          = step_q;

endmodule

// File: rtl/cw_key_conditioner.sv
// Multi-key debounce/long-press/auto-repeat conditioner feeding the adjust counters.
module cw_key_conditioner
  import cw_key_pkg::*;
#(
  parameter int N_KEYS      = 3,
  parameter int CLK_HZ      = 1000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 800,
  parameter int REPEAT_MS   = 200
) (
  input  logic              Clk,
  input  logic              pRst,
  input  logic [N_KEYS-1:0] i_Key_n,
  input  logic              i_Enable,
  output logic [N_KEYS-1:0] o_Level,
  output logic [N_KEYS-1:0] o_Press_Pulse,
  output logic [N_KEYS-1:0] o_Release_Pulse,
  output logic [N_KEYS-1:0] o_Long_Pulse,
  output logic [N_KEYS-1:0] o_Step
);

  localparam int DEB  = ms_to_cycles(DEBOUNCE_MS, CLK_HZ);
  localparam int LONG = ms_to_cycles(LONG_MS, CLK_HZ);
  localparam int RPT  = ms_to_cycles(REPEAT_MS, CLK_HZ);
  localparam int CW   = cnt_width(DEB, LONG, RPT);

  if (DEB < 1 || LONG <= DEB || RPT < 1) begin : g_bad_params
    $error("cw_key_conditioner: illegal timing parameters");
  end

  // Enable gating happens at each channel's pulse register input so a
  // disabled event is dropped while the outputs stay registered.
  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    cw_key_channel #(
      .DEB (DEB),
      .LONG(LONG),
      .RPT (RPT),
      .CW  (CW)
    ) u_ch (
      .Clk          (Clk),
      .pRst         (pRst),
      .key_n        (i_Key_n[k]),
      .en           (i_Enable),
      .level        (o_Level[k]),
      .press_pulse  (o_Press_Pulse[k]),
      .release_pulse(o_Release_Pulse[k]),
      .long_pulse   (o_Long_Pulse[k]),
      .step         (o_Step[k])
    );
  end

endmodule

// File: tb/tb_cw_key_conditioner.sv
// Directed bench for cw_key_conditioner; cycle t is the state just after rising edge t.
module tb_cw_key_conditioner;

  logic       Clk = 1'b0;
  logic       pRst = 1'b0;
  logic       i_Enable = 1'b1;
  logic [2:0] i_Key_n = 3'b111;
  logic [2:0] o_Level, o_Press_Pulse, o_Release_Pulse, o_Long_Pulse, o_Step;

  int n_checks = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  cw_key_conditioner dut (
    .Clk            (Clk),
    .pRst           (pRst),
    .i_Key_n        (i_Key_n),
    .i_Enable       (i_Enable),
    .o_Level        (o_Level),
    .o_Press_Pulse  (o_Press_Pulse),
    .o_Release_Pulse(o_Release_Pulse),
    .o_Long_Pulse   (o_Long_Pulse),
    .o_Step         (o_Step)
  );

  wire [14:0] obs = {o_Level, o_Press_Pulse, o_Release_Pulse, o_Long_Pulse, o_Step};

  task automatic do_reset();
    pRst = 1'b1;
    i_Key_n = 3'b111;
    i_Enable = 1'b1;
    repeat (2) @(posedge Clk);
    #1 pRst = 1'b0;
  endtask

  task automatic test_reset();
    #1 pRst = 1'b1;
    #1;
    n_checks++;
    if (obs !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_initial got %b exp %b", obs, 15'd0);
    end
    i_Key_n = 3'b000;
    repeat (30) @(posedge Clk);
    #1;
    n_checks++;
    if (obs !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_held_keys got %b exp %b", obs, 15'd0);
    end
    i_Key_n = 3'b111;
    #1 pRst = 1'b0;
  endtask

  task automatic test_clean_press();
    logic [2:0] lv, pr, rl, lg, st;
    do_reset();
    for (int t = 0; t < 140; t++) begin
      i_Key_n = (t < 100) ? 3'b110 : 3'b111;
      @(posedge Clk); #1;
      lv = (t >= 22 && t <= 121) ? 3'b001 : 3'b000;
      pr = (t == 22) ? 3'b001 : 3'b000;
      rl = (t == 122) ? 3'b001 : 3'b000;
      lg = 3'b000;
      st = pr;
      n_checks++;
      if (obs !== {lv, pr, rl, lg, st}) begin
        n_fail++;
        $display("FAIL clean_press t=%0d got %b exp %b", t, obs, {lv, pr, rl, lg, st});
      end
    end
  endtask

  task automatic test_bounce();
    logic [2:0] lv, pr, rl, lg, st;
    logic k;
    do_reset();
    for (int t = 0; t < 160; t++) begin
      if (t < 12)                k = ((t / 3) % 2) == 1;
      else if (t < 60)           k = 1'b0;
      else if (t >= 100 && t < 115) k = 1'b0;
      else                       k = 1'b1;
      i_Key_n = {1'b1, k, 1'b1};
      @(posedge Clk); #1;
      lv = (t >= 34 && t <= 81) ? 3'b010 : 3'b000;
      pr = (t == 34) ? 3'b010 : 3'b000;
      rl = (t == 82) ? 3'b010 : 3'b000;
      lg = 3'b000;
      st = pr;
      n_checks++;
      if (obs !== {lv, pr, rl, lg, st}) begin
        n_fail++;
        $display("FAIL bounce t=%0d got %b exp %b", t, obs, {lv, pr, rl, lg, st});
      end
    end
  endtask

  task automatic test_long_hold();
    logic [2:0] lv, pr, rl, lg, st;
    do_reset();
    for (int t = 0; t < 1560; t++) begin
      i_Key_n = (t < 1500) ? 3'b011 : 3'b111;
      @(posedge Clk); #1;
      lv = (t >= 22 && t <= 1521) ? 3'b100 : 3'b000;
      pr = (t == 22) ? 3'b100 : 3'b000;
      rl = (t == 1522) ? 3'b100 : 3'b000;
      lg = (t == 822) ? 3'b100 : 3'b000;
      st = (t == 22 || t == 1022 || t == 1222 || t == 1422) ? 3'b100 : 3'b000;
      n_checks++;
      if (obs !== {lv, pr, rl, lg, st}) begin
        n_fail++;
        $display("FAIL long_hold t=%0d got %b exp %b", t, obs, {lv, pr, rl, lg, st});
      end
    end
  endtask

  task automatic test_repeat_bounce();
    logic [2:0] lv, pr, rl, lg, st;
    do_reset();
    for (int t = 0; t < 1560; t++) begin
      i_Key_n = (t < 1500 && !(t >= 1100 && t < 1110)) ? 3'b011 : 3'b111;
      @(posedge Clk); #1;
      lv = (t >= 22 && t <= 1521) ? 3'b100 : 3'b000;
      pr = (t == 22) ? 3'b100 : 3'b000;
      rl = (t == 1522) ? 3'b100 : 3'b000;
      lg = (t == 822) ? 3'b100 : 3'b000;
      st = (t == 22 || t == 1022 || t == 1232 || t == 1432) ? 3'b100 : 3'b000;
      n_checks++;
      if (obs !== {lv, pr, rl, lg, st}) begin
        n_fail++;
        $display("FAIL repeat_bounce t=%0d got %b exp %b", t, obs, {lv, pr, rl, lg, st});
      end
    end
  endtask

  task automatic test_simultaneous_enable();
    logic [2:0] lv, pr, rl, lg, st;
    do_reset();
    for (int t = 0; t < 200; t++) begin
      i_Key_n[0] = !(t < 60);
      i_Key_n[2] = !(t < 60);
      i_Key_n[1] = !(t >= 100 && t < 160);
      i_Enable   = !(t >= 100 && t < 140);
      @(posedge Clk); #1;
      lv = ((t >= 22 && t <= 81) ? 3'b101 : 3'b000) | ((t >= 122 && t <= 181) ? 3'b010 : 3'b000);
      pr = (t == 22) ? 3'b101 : 3'b000;
      rl = (t == 82) ? 3'b101 : ((t == 182) ? 3'b010 : 3'b000);
      lg = 3'b000;
      st = pr;
      n_checks++;
      if (obs !== {lv, pr, rl, lg, st}) begin
        n_fail++;
        $display("FAIL simul_enable t=%0d got %b exp %b", t, obs, {lv, pr, rl, lg, st});
      end
    end
    i_Enable = 1'b1;
  endtask

  task automatic test_reset_mid_hold();
    logic [2:0] lv, pr, rl, lg, st;
    do_reset();
    for (int t = 0; t < 500; t++) begin
      i_Key_n = 3'b110;
      @(posedge Clk); #1;
      lv = (t >= 22) ? 3'b001 : 3'b000;
      pr = (t == 22) ? 3'b001 : 3'b000;
      rl = 3'b000;
      lg = 3'b000;
      st = pr;
      n_checks++;
      if (obs !== {lv, pr, rl, lg, st}) begin
        n_fail++;
        $display("FAIL mid_hold_pre t=%0d got %b exp %b", t, obs, {lv, pr, rl, lg, st});
      end
    end
    pRst = 1'b1;
    #1;
    n_checks++;
    if (obs !== 15'd0) begin
      n_fail++;
      $display("FAIL mid_hold_async_reset got %b exp %b", obs, 15'd0);
    end
    repeat (2) @(posedge Clk);
    #1 pRst = 1'b0;
    for (int t = 0; t < 900; t++) begin
      @(posedge Clk); #1;
      lv = (t >= 22) ? 3'b001 : 3'b000;
      pr = (t == 22) ? 3'b001 : 3'b000;
      rl = 3'b000;
      lg = (t == 822) ? 3'b001 : 3'b000;
      st = pr;
      n_checks++;
      if (obs !== {lv, pr, rl, lg, st}) begin
        n_fail++;
        $display("FAIL mid_hold_post t=%0d got %b exp %b", t, obs, {lv, pr, rl, lg, st});
      end
    end
    i_Key_n = 3'b111;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_hold();
    test_repeat_bounce();
    test_simultaneous_enable();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
